rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for an N:1 data mux.
- Shares one registered output channel between N_REQ requesters.
- Picks a winner fairly, drives the mux select, captures the winner's data and presents it on a valid/ready output port.
- Sits in front of any shared downstream consumer that previously took a single mux output.

Parameters:
- N_REQ, 4, number of requesters; allowed range 2..16.
- DATA_W, 8, width of each requester's data word.
- SEL_W, 2, select/index width; must equal ceil(log2(N_REQ)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester request; bit i belongs to requester i.
- in_data  input  N_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- grant  output  N_REQ  one-hot capture strobe, combinational; all zero when nothing is captured.
- sel  output  SEL_W  registered index of the requester whose data is in out_data.
- out_valid  output  1  output data valid.
- out_data  output  DATA_W  registered captured data.
- out_ready  input  1  downstream accepts out_data when high together with out_valid.

Behaviour:
- Reset (rst_n low, async): state=IDLE, out_valid=0, out_data=0, sel=0, priority pointer ptr=N_REQ-1, so requester 0 has highest priority first. grant=0 while in reset.
- Reset mid-transaction discards the held word; no grant is issued during reset.
- Arbitration: the winner is the first i with req[i]=1, searching ptr+1, ptr+2, … modulo N_REQ (wrap-around).
- "Capture opportunity": state==IDLE, or state==BUSY with out_ready=1.
- Capture: at a capture opportunity with |req=1:
  - grant[winner]=1 in that cycle.
  - On the clock edge: out_data<=in_data[winner], sel<=winner, ptr<=winner, out_valid<=1, state<=BUSY.
- IDLE with req=0: nothing changes; out_valid stays 0.
- BUSY with out_ready=0: out_data, sel, out_valid and ptr are held; grant=0, whatever req is.
- BUSY with out_ready=1 and req=0: out_valid<=0, state<=IDLE. out_data and sel keep their last values.
- BUSY with out_ready=1 and |req=1: the handshake completes and the next winner is captured in the same cycle. Throughput is one word per clock.
- Latency: req rising in IDLE gives out_valid high on the next edge (1 cycle).
- Requester rules:
  - Hold req high and in_data stable until the cycle grant[i] is seen.
  - May drop req, or present new data, from the following cycle.
  - Dropping req before grant withdraws the request; no capture occurs for it.
- Fairness: a continuously requesting requester waits at most N_REQ-1 captures.
- Only req bits sampled in the capture cycle participate.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Reset then req=4'b0100, in_data word2=8'hA5, out_ready=1 -> grant=4'b0100 for 1 cycle; next cycle out_valid=1, out_data=8'hA5, sel=2; then out_valid=0 once req drops.
- req=4'b1111 held (each requester drops req after its grant and re-raises it), words 8'h10/8'h11/8'h12/8'h13, out_ready=1 -> captures in order 0,1,2,3,0 on consecutive cycles; out_valid high continuously.
- req=4'b0011, out_ready=0 for 5 cycles after the first capture -> out_data=word0, sel=0 held; grant=0 throughout the stall; the cycle out_ready rises, grant=4'b0010 and next cycle sel=1.
- Wrap: ptr=3 (last winner 3), req=4'b1001 -> winner 0, not 3; then req=4'b1000 -> winner 3.
- Assert rst_n=0 asynchronously mid-cycle while BUSY with out_ready=0 -> out_valid, out_data and sel go to 0 immediately without a clock edge. After release with req=4'b0010, requester 1 wins and ptr restarts from N_REQ-1.
- req pulses high then drops while BUSY with out_ready=0 -> no grant and no capture; after handshake, state returns to IDLE and out_valid=0.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter feeding one registered valid/ready output channel.
// Captures the winning requester's word and holds it until accepted.
module rr_mux_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  output logic [N_REQ-1:0]        grant,
  output logic [SEL_W-1:0]        sel,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t state_q, state_d;

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [SEL_W-1:0]  win;
  logic [DATA_W-1:0] win_data;
  logic [SEL_W-1:0]  hi_i, lo_i;
  logic              hi_f, lo_f;
  logic              cap;

  // First request strictly above ptr wins; else lowest request wraps.
  always_comb begin
    hi_f = 1'b0;
    lo_f = 1'b0;
    hi_i = '0;
    lo_i = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i] && !lo_f) begin
        lo_f = 1'b1;
        lo_i = SEL_W'(i);
      end
      if (req[i] && !hi_f && (SEL_W'(i) > ptr_q)) begin
        hi_f = 1'b1;
        hi_i = SEL_W'(i);
      end
    end
    win = hi_f ? hi_i : lo_i;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (SEL_W'(i) == win) begin
        win_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    data_d  = data_q;
    grant   = '0;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: cap = rst_n && (|req);
      BUSY: cap = rst_n && (|req) && out_ready;
      default: cap = 1'b0;
    endcase
    if (cap) begin
      grant   = N_REQ'(1) << win;
      state_d = BUSY;
      ptr_d   = win;
      sel_d   = win;
      valid_d = 1'b1;
      data_d  = win_data;
    end else if (state_q == BUSY && out_ready) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= SEL_W'(N_REQ - 1);
      sel_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus random traffic
// checked against a queue-free behavioural round-robin model.
module tb_rr_mux_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   grant;
  logic [S-1:0]   sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;

  int n_cmp = 0;
  int n_mis = 0;

  int         m_ptr;
  int         m_sel;
  logic       m_valid;
  logic [W-1:0] m_data;

  rr_mux_arbiter #(
    .N_REQ (N),
    .DATA_W(W),
    .SEL_W (S)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .in_data  (in_data),
    .grant    (grant),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int m_winner(logic [N-1:0] r, int p);
    for (int k = 1; k <= N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] word_of(int i);
    return in_data[i*W +: W];
  endfunction

  task automatic m_reset();
    m_ptr   = N - 1;
    m_sel   = 0;
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic cyc();
    int           w;
    logic         opp;
    logic [N-1:0] eg;
    logic [W-1:0] wd;
    #1;
    w   = m_winner(req, m_ptr);
    opp = !m_valid || out_ready;
    eg  = '0;
    wd  = '0;
    if (opp && w >= 0) begin
      eg = N'(1) << w;
      wd = word_of(w);
    end
    chk("grant", 32'(grant), 32'(eg));
    @(posedge clk);
    if (opp && w >= 0) begin
      m_data  = wd;
      m_sel   = w;
      m_ptr   = w;
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("valid", 32'(out_valid), 32'(m_valid));
    chk("data", 32'(out_data), 32'(m_data));
    chk("sel", 32'(sel), 32'(m_sel));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    m_reset();
    #2;
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst data", 32'(out_data), 32'd0);
    chk("rst sel", 32'(sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    in_data   = '0;
    out_ready = 1'b0;
    m_reset();

    // Single request from requester 2
    do_reset();
    req       = 4'b0100;
    in_data   = 32'h00A5_0000;
    out_ready = 1'b1;
    cyc();
    chk("t1 data", 32'(out_data), 32'hA5);
    chk("t1 sel", 32'(sel), 32'd2);
    req = '0;
    cyc();
    chk("t1 idle", 32'(out_valid), 32'd0);

    // All requesting: strict rotation 0,1,2,3,0
    do_reset();
    in_data   = 32'h1312_1110;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req = '1;
      cyc();
      chk("t2 sel", 32'(sel), 32'(k % 4));
      chk("t2 data", 32'(out_data), 32'h10 + 32'(k % 4));
    end

    // Stall holds the word and suppresses grant
    do_reset();
    in_data   = 32'h4433_2211;
    req       = 4'b0011;
    out_ready = 1'b1;
    cyc();
    chk("t3 sel0", 32'(sel), 32'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    chk("t3 held", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    cyc();
    chk("t3 sel1", 32'(sel), 32'd1);

    // Wrap-around after requester 3
    req = 4'b1000;
    cyc();
    chk("t4 w3", 32'(sel), 32'd3);
    req = 4'b1001;
    cyc();
    chk("t4 wrap", 32'(sel), 32'd0);
    req = 4'b1000;
    cyc();
    chk("t4 last", 32'(sel), 32'd3);

    // Asynchronous reset while stalled
    req       = 4'b0010;
    out_ready = 1'b0;
    cyc();
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("ar valid", 32'(out_valid), 32'd0);
    chk("ar data", 32'(out_data), 32'd0);
    chk("ar sel", 32'(sel), 32'd0);
    chk("ar grant", 32'(grant), 32'd0);
    req = '0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req       = 4'b0010;
    out_ready = 1'b1;
    cyc();
    chk("ar win1", 32'(sel), 32'd1);

    // Request withdrawn during a stall never captures
    req = 4'b0001;
    cyc();
    out_ready = 1'b0;
    req       = 4'b0100;
    cyc();
    req = '0;
    cyc();
    out_ready = 1'b1;
    cyc();
    chk("t6 idle", 32'(out_valid), 32'd0);
    chk("t6 sel", 32'(sel), 32'd0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      req       = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
